// File: rtl/mips_pkg.sv
// mips_pkg: shared aluctrl codes plus MIPS opcode and funct field values.
// Ports: none (package).
package mips_pkg;
    localparam logic [4:0] ALU_AND     = 5'b00000;
    localparam logic [4:0] ALU_OR      = 5'b00001;
    localparam logic [4:0] ALU_ADD     = 5'b00010;
    localparam logic [4:0] ALU_SUB     = 5'b00110;
    localparam logic [4:0] ALU_PASS_D2 = 5'b00111;
    localparam logic [4:0] ALU_NOR     = 5'b01100;
    localparam logic [4:0] ALU_SLL     = 5'b01101;
    localparam logic [4:0] ALU_SRL     = 5'b01110;
    localparam logic [4:0] ALU_SRA     = 5'b01111;
    localparam logic [4:0] ALU_SLT     = 5'b10000;
    localparam logic [4:0] ALU_NOP     = 5'b11111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational opcode/funct/imm decode into aluctrl and ALU operands.
// Ports: opcode, funct, shamt, imm, rs, rt in; aluctrl, d1, d2 out;
// illegal out only when ALU_ISSUE_ILLEGAL_EN is defined.
module alu_decode
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
`ifdef ALU_ISSUE_ILLEGAL_EN
    output logic              illegal,
`endif
    output logic [4:0]        aluctrl,
    output logic [DATA_W-1:0] d1,
    output logic [DATA_W-1:0] d2
);
    logic [DATA_W-1:0] sx, zx, hi, shz;

    assign sx  = {{(DATA_W-16){imm[15]}}, imm};
    assign zx  = {{(DATA_W-16){1'b0}}, imm};
    assign hi  = DATA_W'({imm, 16'h0000});
    assign shz = DATA_W'(shamt);

    always_comb begin
        aluctrl = ALU_NOP;
        d1      = '0;
        d2      = '0;
        case (opcode)
            OP_RTYPE: begin
                d1 = rs;
                d2 = rt;
                case (funct)
                    F_ADD, F_ADDU: aluctrl = ALU_ADD;
                    F_SUB, F_SUBU: aluctrl = ALU_SUB;
                    F_AND:         aluctrl = ALU_AND;
                    F_OR:          aluctrl = ALU_OR;
                    F_NOR:         aluctrl = ALU_NOR;
                    F_SLT:         aluctrl = ALU_SLT;
                    F_SLL, F_SRL, F_SRA: begin
                        aluctrl = funct == F_SLL ? ALU_SLL : funct == F_SRL ? ALU_SRL : ALU_SRA;
                        d1      = rt;
                        d2      = shz;
                    end
                    default: begin
                        d1 = '0;
                        d2 = '0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                aluctrl = ALU_ADD;
                d1      = rs;
                d2      = sx;
            end
            OP_SLTI: begin
                aluctrl = ALU_SLT;
                d1      = rs;
                d2      = sx;
            end
            OP_ANDI, OP_ORI: begin
                aluctrl = opcode == OP_ANDI ? ALU_AND : ALU_OR;
                d1      = rs;
                d2      = zx;
            end
            OP_LUI: begin
                aluctrl = ALU_PASS_D2;
                d1      = rs;
                d2      = hi;
            end
            OP_BEQ, OP_BNE: begin
                aluctrl = ALU_SUB;
                d1      = rs;
                d2      = rt;
            end
            default: ;
        endcase
    end

`ifdef ALU_ISSUE_ILLEGAL_EN
    // No decodable instruction maps to NOP, so NOP marks exactly the undecodable ones.
    assign illegal = aluctrl == ALU_NOP;
`endif
endmodule

// File: rtl/alu_issue.sv
// alu_issue: ID/EX issue stage, decodes ALU ops and holds them in a main + skid register pair.
// Ports: clk, rst (async, active high), flush; in_valid/in_ready with opcode, funct, shamt,
// imm, rs/rt data; out_valid/out_ready with d1, d2, aluctrl.
// Optional: ALU_ISSUE_ILLEGAL_EN adds out_illegal, registered alongside the op.
module alu_issue
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [5:0]        in_funct,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_d1,
    output logic [DATA_W-1:0] out_d2,
`ifdef ALU_ISSUE_ILLEGAL_EN
    output logic              out_illegal,
`endif
    output logic [4:0]        out_aluctrl
);
`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam int EW = 2*DATA_W + 6;
`else
    localparam int EW = 2*DATA_W + 5;
`endif
    // An entry is {aluctrl, d1, d2[, illegal]}; the NOP entry has all operand bits zero.
    localparam logic [EW-1:0] NOP_ENTRY = {ALU_NOP, {(EW-5){1'b0}}};

    logic [4:0]        dec_aluctrl;
    logic [DATA_W-1:0] dec_d1, dec_d2;
    logic [EW-1:0]     dec, main_q, skid_q;
    logic              main_valid, skid_valid, accept, load_main;

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic dec_illegal;
`endif

    alu_decode #(.DATA_W(DATA_W)) u_decode (
        .opcode  (in_opcode),
        .funct   (in_funct),
        .shamt   (in_shamt),
        .imm     (in_imm),
        .rs      (in_rs_data),
        .rt      (in_rt_data),
`ifdef ALU_ISSUE_ILLEGAL_EN
        .illegal (dec_illegal),
`endif
        .aluctrl (dec_aluctrl),
        .d1      (dec_d1),
        .d2      (dec_d2)
    );

`ifdef ALU_ISSUE_ILLEGAL_EN
    assign dec = {dec_aluctrl, dec_d1, dec_d2, dec_illegal};
    assign {out_aluctrl, out_d1, out_d2, out_illegal} = main_q;
`else
    assign dec = {dec_aluctrl, dec_d1, dec_d2};
    assign {out_aluctrl, out_d1, out_d2} = main_q;
`endif

    // in_ready depends only on the skid flop, so out_ready never reaches it combinationally.
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid && !skid_valid;
    assign load_main = !main_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= NOP_ENTRY;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= NOP_ENTRY;
        end else if (load_main) begin
            // A full skid implies in_ready was low, so it never competes with an accept.
            main_valid <= skid_valid || accept;
            if (skid_valid) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q <= dec;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: table-driven scoreboard bench for alu_issue.
module tb_alu_issue;
    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  ac;
        logic [31:0] d1;
        logic [31:0] d2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [5:0]  in_opcode, in_funct;
    logic [4:0]  in_shamt, out_aluctrl;
    logic [15:0] in_imm;
    logic [31:0] in_rs_data, in_rt_data, out_d1, out_d2;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic        out_illegal;
`endif

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    logic [68:0] q[$];
    logic [68:0] cur;
    vec_t        tv[24];

    always #5 clk = ~clk;

    alu_issue #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct    (in_funct),
        .in_shamt    (in_shamt),
        .in_imm      (in_imm),
        .in_rs_data  (in_rs_data),
        .in_rt_data  (in_rt_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_d1      (out_d1),
        .out_d2      (out_d2),
`ifdef ALU_ISSUE_ILLEGAL_EN
        .out_illegal (out_illegal),
`endif
        .out_aluctrl (out_aluctrl)
    );

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [4:0] ac, input logic [31:0] d1, input logic [31:0] d2);
        vec_t v;
        v.op = op; v.fn = fn; v.sh = sh; v.imm = imm; v.rs = rs; v.rt = rt;
        v.ac = ac; v.d1 = d1; v.d2 = d2;
        return v;
    endfunction

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int i);
        in_valid   = 1'b1;
        in_opcode  = tv[i].op;
        in_funct   = tv[i].fn;
        in_shamt   = tv[i].sh;
        in_imm     = tv[i].imm;
        in_rs_data = tv[i].rs;
        in_rt_data = tv[i].rt;
        cur        = {tv[i].ac, tv[i].d1, tv[i].d2};
    endtask

    // Called between edges: score this cycle's handshakes, then advance one clock.
    task automatic step();
        logic [68:0] e;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_issue: got %h expected no output", {out_aluctrl, out_d1, out_d2});
            end else begin
                e = q.pop_front();
                check("issue", {out_aluctrl, out_d1, out_d2}, e);
`ifdef ALU_ISSUE_ILLEGAL_EN
                check("illegal", out_illegal, e[68:64] == 5'h1f);
`endif
                delivered++;
            end
        end
        if (flush) q.delete();
        else if (in_valid && in_ready) q.push_back(cur);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit sent;
        tv[0]  = mk(6'h00, 6'h20, 5'd0,  16'h0000, 32'd5,        32'd7,        5'h02, 32'd5,        32'd7);
        tv[1]  = mk(6'h00, 6'h21, 5'd0,  16'h0000, 32'd1,        32'd2,        5'h02, 32'd1,        32'd2);
        tv[2]  = mk(6'h00, 6'h22, 5'd0,  16'h0000, 32'd9,        32'd3,        5'h06, 32'd9,        32'd3);
        tv[3]  = mk(6'h00, 6'h23, 5'd0,  16'h0000, 32'h10,       32'h20,       5'h06, 32'h10,       32'h20);
        tv[4]  = mk(6'h00, 6'h24, 5'd0,  16'h0000, 32'hF0F0,     32'hFF00,     5'h00, 32'hF0F0,     32'hFF00);
        tv[5]  = mk(6'h00, 6'h25, 5'd0,  16'h0000, 32'h11,       32'h22,       5'h01, 32'h11,       32'h22);
        tv[6]  = mk(6'h00, 6'h27, 5'd0,  16'h0000, 32'h33,       32'h44,       5'h0C, 32'h33,       32'h44);
        tv[7]  = mk(6'h00, 6'h2A, 5'd0,  16'h0000, 32'h55,       32'h66,       5'h10, 32'h55,       32'h66);
        tv[8]  = mk(6'h00, 6'h00, 5'd4,  16'h0000, 32'd99,       32'h1,        5'h0D, 32'h1,        32'd4);
        tv[9]  = mk(6'h00, 6'h02, 5'd31, 16'h0000, 32'd5,        32'h80000000, 5'h0E, 32'h80000000, 32'd31);
        tv[10] = mk(6'h00, 6'h03, 5'd1,  16'h0000, 32'd5,        32'hF0000000, 5'h0F, 32'hF0000000, 32'd1);
        tv[11] = mk(6'h00, 6'h3F, 5'd2,  16'h0000, 32'd5,        32'd6,        5'h1F, 32'd0,        32'd0);
        tv[12] = mk(6'h08, 6'h2A, 5'd0,  16'hFFFE, 32'd10,       32'hDEAD,     5'h02, 32'd10,       32'hFFFFFFFE);
        tv[13] = mk(6'h09, 6'h2A, 5'd0,  16'h0005, 32'd3,        32'hDEAD,     5'h02, 32'd3,        32'd5);
        tv[14] = mk(6'h0A, 6'h2A, 5'd0,  16'h8000, 32'd7,        32'hDEAD,     5'h10, 32'd7,        32'hFFFF8000);
        tv[15] = mk(6'h0C, 6'h2A, 5'd0,  16'hFFFF, 32'h12345678, 32'hDEAD,     5'h00, 32'h12345678, 32'h0000FFFF);
        tv[16] = mk(6'h0D, 6'h2A, 5'd0,  16'h8001, 32'd1,        32'hDEAD,     5'h01, 32'd1,        32'h00008001);
        tv[17] = mk(6'h0F, 6'h2A, 5'd0,  16'h1234, 32'h77,       32'hDEAD,     5'h07, 32'h77,       32'h12340000);
        tv[18] = mk(6'h23, 6'h2A, 5'd0,  16'hFFFC, 32'd100,      32'hDEAD,     5'h02, 32'd100,      32'hFFFFFFFC);
        tv[19] = mk(6'h2B, 6'h2A, 5'd0,  16'h0010, 32'd200,      32'hDEAD,     5'h02, 32'd200,      32'h10);
        tv[20] = mk(6'h04, 6'h2A, 5'd0,  16'h0003, 32'd8,        32'd8,        5'h06, 32'd8,        32'd8);
        tv[21] = mk(6'h05, 6'h2A, 5'd0,  16'hFFFF, 32'd1,        32'd2,        5'h06, 32'd1,        32'd2);
        tv[22] = mk(6'h3F, 6'h20, 5'd3,  16'h1234, 32'd9,        32'd9,        5'h1F, 32'd0,        32'd0);
        tv[23] = mk(6'h02, 6'h20, 5'd3,  16'h1234, 32'd9,        32'd9,        5'h1F, 32'd0,        32'd0);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_funct = '0; in_shamt = '0; in_imm = '0;
        in_rs_data = '0; in_rt_data = '0; cur = '0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_aluctrl", out_aluctrl, 5'h1f);
        check("reset_d1_d2", {out_d1, out_d2}, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);

        // One-cycle latency on the first add.
        out_ready = 1'b1;
        drive(0);
        step();
        check("latency_valid", out_valid, 1'b1);
        check("latency_add", {out_aluctrl, out_d1, out_d2}, {5'h02, 32'd5, 32'd7});

        // Full decode table streamed at full throughput.
        for (int i = 0; i < 24; i++) begin
            check("stream_in_ready", in_ready, 1'b1);
            drive(i);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        check("stream_count", delivered, 25);

        // Three ops with a two-cycle downstream stall mid-stream.
        drive(0);
        step();
        drive(12);
        out_ready = 1'b0;
        step();
        check("skid_full_ready", in_ready, 1'b0);
        check("stall_hold", {out_valid, out_aluctrl, out_d1, out_d2}, {1'b1, 5'h02, 32'd5, 32'd7});
        drive(8);
        step();
        check("stall_stable", {out_valid, out_aluctrl, out_d1, out_d2}, {1'b1, 5'h02, 32'd5, 32'd7});
        out_ready = 1'b1;
        sent = 1'b0;
        for (int k = 0; k < 10 && !sent; k++) begin
            sent = in_ready;
            step();
        end
        check("stall_third_accepted", sent, 1'b1);
        in_valid = 1'b0;
        repeat (4) step();
        check("stall_count", delivered, 28);

        // Flush with main and skid full and a new op offered.
        out_ready = 1'b0;
        drive(1);
        step();
        drive(2);
        step();
        check("flush_pre_ready", in_ready, 1'b0);
        drive(3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_aluctrl", out_aluctrl, 5'h1f);

        // Flush discards an op accepted in the same cycle.
        drive(4);
        step();
        drive(5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_accept_dropped", out_valid, 1'b0);
        out_ready = 1'b1;
        repeat (2) step();
        drive(6);
        step();
        in_valid = 1'b0;
        step();
        check("post_flush_count", delivered, 29);

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        drive(7);
        step();
        drive(9);
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_out", {out_aluctrl, out_d1, out_d2}, {5'h1f, 64'h0});
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_ready", {in_ready, out_valid}, 2'b10);
        out_ready = 1'b1;
        drive(17);
        step();
        in_valid = 1'b0;
        step();
        check("final_count", delivered, 30);
        check("scoreboard_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
